ps2_scancode_decoder: RTL and testbench

//  Consumes PS/2 set-2 scan-code bytes, one per code_valid strobe, from the keyboard receive stage.

---
 rtl/ps2_scancode_decoder_if.sv | 25 ++
 rtl/ps2_scancode_decoder.sv | 159 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Keyboard decoder port bundle: scan-code byte input plus the key-event read port.
interface ps2_scancode_decoder_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    code_in;
  logic                          code_valid;
  logic                          key_rd;
  logic                          ovf_clr;
  logic [7:0]                    key_code;
  logic                          key_ext;
  logic                          key_break;
  logic                          key_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output code_in, code_valid, key_rd, ovf_clr,
    input  key_code, key_ext, key_break, key_valid, fifo_count, overflow
  );

  modport slave (
    input  code_in, code_valid, key_rd, ovf_clr,
    output key_code, key_ext, key_break, key_valid, fifo_count, overflow
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 set-2 prefix sequences (E0/F0/E1) into key events and queues them
// in a show-ahead FIFO whose head is presented on registered outputs.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ps2_scancode_decoder_if.slave   kbd
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [47:0] STATUS_CODES = {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         pcnt_reg, pcnt_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic [5:0]         status_hit;
  logic               is_status;
  logic               push_req;
  logic [9:0]         push_data;  // {code, ext, brk}

  logic [9:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               pop, full, push_ok;
  logic [9:0]         head_next;
  logic [9:0]         head_reg;
  logic               key_valid_reg, overflow_reg, overflow_next;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_status
      assign status_hit[gi] = (kbd.code_in == STATUS_CODES[gi*8 +: 8]);
    end
  endgenerate
  assign is_status = |status_hit;

  always_comb begin
    state_next   = state_reg;
    pcnt_next    = pcnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    push_req     = 1'b0;
    push_data    = {kbd.code_in, 2'b00};
    if (kbd.code_valid) begin
      tmo_cnt_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (kbd.code_in == 8'hE0)      state_next = ST_EXT;
          else if (kbd.code_in == 8'hF0) state_next = ST_BRK;
          else if (kbd.code_in == 8'hE1) begin
            state_next = ST_PAUSE;
            pcnt_next  = 3'd7;
          end else if (!is_status)       push_req = 1'b1;
        end
        ST_EXT: begin
          if (kbd.code_in == 8'hF0) state_next = ST_EXT_BRK;
          else if (kbd.code_in != 8'hE0) begin
            push_req   = 1'b1;
            push_data  = {kbd.code_in, 2'b10};
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (kbd.code_in != 8'hE0 && kbd.code_in != 8'hF0) begin
            push_req   = 1'b1;
            push_data  = {kbd.code_in, 2'b01};
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (kbd.code_in != 8'hE0 && kbd.code_in != 8'hF0) begin
            push_req   = 1'b1;
            push_data  = {kbd.code_in, 2'b11};
            state_next = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // Pause carries no break code; the 8-byte burst becomes one E1 make.
          if (pcnt_reg == 3'd1) begin
            push_req   = 1'b1;
            push_data  = {8'hE1, 2'b00};
            pcnt_next  = 3'd0;
            state_next = ST_IDLE;
          end else begin
            pcnt_next = pcnt_reg - 3'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE) begin
      if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_next   = ST_IDLE;
        pcnt_next    = 3'd0;
        tmo_cnt_next = '0;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
      end
    end
  end

  always_comb begin
    pop           = kbd.key_rd && key_valid_reg;
    full          = (count_reg == CNT_W'(FIFO_DEPTH));
    push_ok       = push_req && (!full || pop);
    rd_ptr_next   = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    wr_ptr_next   = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    // The new head may be the entry being written on this very edge.
    if (count_next == '0)                          head_next = '0;
    else if (push_ok && wr_ptr_reg == rd_ptr_next) head_next = push_data;
    else                                           head_next = mem[rd_ptr_next];
    overflow_next = overflow_reg;
    if (kbd.ovf_clr)                 overflow_next = 1'b0;
    if (push_req && full && !pop)    overflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      pcnt_reg      <= '0;
      tmo_cnt_reg   <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      head_reg      <= '0;
      key_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pcnt_reg      <= pcnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      head_reg      <= head_next;
      key_valid_reg <= (count_next != '0);
      overflow_reg  <= overflow_next;
    end
  end

  assign kbd.key_code   = head_reg[9:2];
  assign kbd.key_ext    = head_reg[1];
  assign kbd.key_break  = head_reg[0];
  assign kbd.key_valid  = key_valid_reg;
  assign kbd.fifo_count = count_reg;
  assign kbd.overflow   = overflow_reg;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefix folding, status drops, pause,
// FIFO full/overflow behaviour, prefix timeout and mid-sequence reset.
module tb_ps2_scancode_decoder;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  ps2_scancode_decoder_if #(.FIFO_DEPTH(4)) kbd ();

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kbd     (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Head comparison packs {valid, code, ext, brk}.
  task automatic check_head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check(tag, {21'd0, kbd.key_valid, kbd.key_code, kbd.key_ext, kbd.key_break},
          {21'd0, 1'b1, code, ext, brk});
  endtask

  task automatic cycle(input logic [7:0] b, input logic v, input logic rd, input logic clr);
    @(negedge clk);
    kbd.code_in    = b;
    kbd.code_valid = v;
    kbd.key_rd     = rd;
    kbd.ovf_clr    = clr;
    @(posedge clk);
    #1;
    kbd.code_valid = 1'b0;
    kbd.key_rd     = 1'b0;
    kbd.ovf_clr    = 1'b0;
    $display("t=%0t byte=%02h v=%0d rd=%0d clr=%0d -> valid=%0d head=%02h/%0d/%0d cnt=%0d ovf=%0d",
             $time, b, v, rd, clr, kbd.key_valid, kbd.key_code, kbd.key_ext, kbd.key_break,
             kbd.fifo_count, kbd.overflow);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {18'd0, kbd.key_code, kbd.key_ext, kbd.key_break, kbd.key_valid,
                kbd.fifo_count, kbd.overflow}, 32'd0);
  endtask

  logic [7:0] pause_seq [8];
  logic [7:0] drain_exp [3];

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    kbd.code_in    = 8'h00;
    kbd.code_valid = 1'b0;
    kbd.key_rd     = 1'b0;
    kbd.ovf_clr    = 1'b0;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    drain_exp = '{8'h24, 8'h2D, 8'h33};

    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: make then break of the same key
    send(8'h1C);
    check_head("t1_make_latency", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    send(8'h1C);
    check("t1_count", 32'(kbd.fifo_count), 32'd2);
    check_head("t1_head_hold", 8'h1C, 1'b0, 1'b0);
    pop();
    check_head("t1_break", 8'h1C, 1'b0, 1'b1);
    pop();
    check_outputs_zero("t1_empty");

    // 2: extended make/break with status bytes interleaved
    send(8'hE0); send(8'h75); send(8'hFA); send(8'hAA);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_count", 32'(kbd.fifo_count), 32'd2);
    check_head("t2_ext_make", 8'h75, 1'b1, 1'b0);
    pop();
    check_head("t2_ext_break", 8'h75, 1'b1, 1'b1);
    pop();

    // 3: pause sequence collapses to one event after the 8th byte
    for (int i = 0; i < 7; i++) send(pause_seq[i]);
    check("t3_count_before_last", 32'(kbd.fifo_count), 32'd0);
    send(pause_seq[7]);
    check("t3_count", 32'(kbd.fifo_count), 32'd1);
    check_head("t3_pause", 8'hE1, 1'b0, 1'b0);
    pop();

    // 4: overflow, push+pop while full, set-wins, clear
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    check("t4_count_full", 32'(kbd.fifo_count), 32'd4);
    check("t4_ovf_set", 32'(kbd.overflow), 32'd1);
    check_head("t4_head_first", 8'h15, 1'b0, 1'b0);
    cycle(8'h33, 1'b1, 1'b1, 1'b0);
    check("t4_count_pushpop", 32'(kbd.fifo_count), 32'd4);
    check_head("t4_head_adv", 8'h1D, 1'b0, 1'b0);
    check("t4_ovf_hold", 32'(kbd.overflow), 32'd1);
    cycle(8'h34, 1'b1, 1'b0, 1'b1);
    check("t4_ovf_set_wins", 32'(kbd.overflow), 32'd1);
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    check("t4_ovf_clr", 32'(kbd.overflow), 32'd0);
    pop();
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("t4_drain%0d", i), drain_exp[i], 1'b0, 1'b0);
      pop();
    end
    check_outputs_zero("t4_empty");

    // 5: prefix survives 9 idle cycles, abandoned after 10
    send(8'hF0);
    idle(9);
    send(8'h1C);
    check_head("t5_no_timeout", 8'h1C, 1'b0, 1'b1);
    pop();
    send(8'hF0);
    idle(10);
    send(8'h1C);
    check_head("t5_timeout", 8'h1C, 1'b0, 1'b0);
    check("t5_count", 32'(kbd.fifo_count), 32'd1);
    pop();

    // 6: reset mid-sequence with an event queued
    send(8'h29);
    send(8'hE0);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_outputs_zero("t6_async_reset");
    @(posedge clk);
    #1 check_outputs_zero("t6_in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h1C);
    check_head("t6_after_reset", 8'h1C, 1'b0, 1'b0);
    check("t6_count", 32'(kbd.fifo_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
